// File: rtl/hub75_rx.sv
// HUB75 panel snooper: resynchronises the panel pins, captures each shifted line into a
// ping-pong buffer and replays it on an AXI-Stream port. Optional macro HUB75_RX_OE_STATS_EN.
module hub75_rx #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       aresetn,
  input  logic       hub75io_clk,
  input  logic       hub75io_lat,
  input  logic       hub75io_oe,
  input  logic [1:0] hub75io_r,
  input  logic [1:0] hub75io_g,
  input  logic [1:0] hub75io_b,
  input  logic       hub75io_row_a,
  input  logic       hub75io_row_b,
  input  logic       hub75io_row_c,
  input  logic       hub75io_row_d,
  input  logic       hub75io_row_e,
  output logic [7:0] out_tdata,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic       out_tlast,
  output logic [4:0] out_row,
  output logic       err_overflow,
  output logic       err_toolong,
  output logic [15:0] line_count,
  output logic [31:0] oe_cycles
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(WIDTH);
  localparam int NB = 14;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  // Synchroniser reset value holds oe high so a blanked panel is assumed after reset.
  localparam logic [NB-1:0] PIN_IDLE = 14'h0800;

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  logic [NB-1:0] pins;
  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] sync_d [SYNC_STAGES];
  logic [NB-1:0] edge_q, edge_d, cur;
  logic          clk_rise, lat_rise, wr_en, swap, is_last, hs;
  logic [5:0]    pix;
  logic [CW-1:0] col_q, col_d, col_inc, len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [5:0]    rdata_q, rdata_d;
  logic [4:0]    row_q, row_d;
  logic          fill_sel_q, fill_sel_d, ovf_q, ovf_d, long_q, long_d;
  logic [15:0]   lines_q, lines_d;
  state_t        state_q, state_d;
  logic [5:0]    mem_q [2][WIDTH];

  assign pins = {hub75io_clk, hub75io_lat, hub75io_oe, hub75io_b, hub75io_g, hub75io_r,
                 hub75io_row_e, hub75io_row_d, hub75io_row_c, hub75io_row_b, hub75io_row_a};
  assign cur      = sync_q[SYNC_STAGES-1];
  assign clk_rise = cur[13] & ~edge_q[13];
  assign lat_rise = cur[12] & ~edge_q[12];
  assign pix      = {edge_q[10], edge_q[8], edge_q[6], edge_q[9], edge_q[7], edge_q[5]};
  assign hs       = (state_q == SEND) && out_tready;
  assign is_last  = (CW'(idx_q) + CW'(1)) == len_q;

  always_comb begin
    sync_d[0] = pins;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    edge_d = cur;
  end

  // A pixel arriving with the latch is counted into the line before the swap decision.
  always_comb begin
    wr_en      = clk_rise && (col_q != WIDTH_C);
    col_inc    = col_q + CW'(wr_en);
    swap       = lat_rise && (col_inc != '0) && (state_q == IDLE);
    col_d      = (lat_rise && (col_inc != '0)) ? '0 : col_inc;
    ovf_d      = ovf_q | (lat_rise && (col_inc != '0) && (state_q != IDLE));
    long_d     = long_q | (clk_rise && (col_q == WIDTH_C));
    fill_sel_d = fill_sel_q ^ swap;
    len_d      = swap ? col_inc : len_q;
    row_d      = swap ? edge_q[4:0] : row_q;
    lines_d    = lines_q + 16'(hs && is_last);
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
      edge_q     <= PIN_IDLE;
      col_q      <= '0;
      len_q      <= '0;
      row_q      <= '0;
      fill_sel_q <= 1'b0;
      ovf_q      <= 1'b0;
      long_q     <= 1'b0;
      lines_q    <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      rdata_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      edge_q     <= edge_d;
      col_q      <= col_d;
      len_q      <= len_d;
      row_q      <= row_d;
      fill_sel_q <= fill_sel_d;
      ovf_q      <= ovf_d;
      long_q     <= long_d;
      lines_q    <= lines_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[fill_sel_q][col_q[AW-1:0]] <= pix;
  end

  // Read address follows the next index so a handshake never costs a bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    case (state_q)
      IDLE: if (swap) state_d = READ;
      READ: state_d = SEND;
      SEND: begin
        idx_d = idx_q;
        if (hs) begin
          if (is_last) state_d = IDLE;
          else idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    rdata_d = mem_q[~fill_sel_q][idx_d];
  end

  always_comb begin
    out_tvalid = (state_q == SEND);
    out_tlast  = out_tvalid && is_last;
    out_tdata  = {2'b00, rdata_q};
    out_row    = row_q;
  end

  assign err_overflow = ovf_q;
  assign err_toolong  = long_q;
  assign line_count   = lines_q;

`ifdef HUB75_RX_OE_STATS_EN
  logic [31:0] oe_cnt_q, oe_cnt_d;
  always_comb begin
    oe_cnt_d = oe_cnt_q;
    if (!edge_q[11] && (oe_cnt_q != '1)) oe_cnt_d = oe_cnt_q + 32'd1;
  end
  always_ff @(posedge clock) begin
    if (!aresetn) oe_cnt_q <= '0;
    else          oe_cnt_q <= oe_cnt_d;
  end
  assign oe_cycles = oe_cnt_q;
`else
  logic oe_unused;
  assign oe_unused = edge_q[11];
  assign oe_cycles = '0;
`endif
endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: pixels are shifted on the HUB75 pins, expected beats are
// queued at latch time and compared against each AXI-Stream handshake.
module tb_hub75_rx;
  logic       clock = 1'b0;
  logic       aresetn = 1'b0;
  logic       hub75io_clk = 1'b0, hub75io_lat = 1'b0, hub75io_oe = 1'b1;
  logic [1:0] hub75io_r = '0, hub75io_g = '0, hub75io_b = '0;
  logic       hub75io_row_a = 1'b0, hub75io_row_b = 1'b0, hub75io_row_c = 1'b0;
  logic       hub75io_row_d = 1'b0, hub75io_row_e = 1'b0;
  logic [7:0] out_tdata;
  logic       out_tvalid, out_tlast;
  logic       out_tready = 1'b0;
  logic [4:0] out_row;
  logic       err_overflow, err_toolong;
  logic [15:0] line_count;
  logic [31:0] oe_cycles;

  typedef struct packed {logic [4:0] r; logic l; logic [7:0] d;} beat_t;
  beat_t      exp_q [$];
  logic [5:0] cur_line [$];
  int checks = 0, errors = 0, beats = 0;

  always #5 clock = ~clock;

  hub75_rx #(.WIDTH(64), .SYNC_STAGES(2)) dut (
    .clock(clock), .aresetn(aresetn),
    .hub75io_clk(hub75io_clk), .hub75io_lat(hub75io_lat), .hub75io_oe(hub75io_oe),
    .hub75io_r(hub75io_r), .hub75io_g(hub75io_g), .hub75io_b(hub75io_b),
    .hub75io_row_a(hub75io_row_a), .hub75io_row_b(hub75io_row_b), .hub75io_row_c(hub75io_row_c),
    .hub75io_row_d(hub75io_row_d), .hub75io_row_e(hub75io_row_e),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_row(out_row),
    .err_overflow(err_overflow), .err_toolong(err_toolong),
    .line_count(line_count), .oe_cycles(oe_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (aresetn === 1'b1 && out_tvalid === 1'b1 && out_tready === 1'b1) begin
      beat_t e;
      beats++;
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 32'({out_row, out_tlast, out_tdata}), 32'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic shift_px(input logic [5:0] p);
    hub75io_r = {p[3], p[0]};
    hub75io_g = {p[4], p[1]};
    hub75io_b = {p[5], p[2]};
    hub75io_clk = 1'b0;
    tick(2);
    hub75io_clk = 1'b1;
    tick(2);
    hub75io_clk = 1'b0;
    cur_line.push_back(p);
  endtask

  task automatic pulse_lat(input logic [4:0] row);
    {hub75io_row_e, hub75io_row_d, hub75io_row_c, hub75io_row_b, hub75io_row_a} = row;
    tick(2);
    hub75io_lat = 1'b1;
    tick(2);
    hub75io_lat = 1'b0;
    tick(2);
  endtask

  task automatic expect_line(input logic [4:0] row);
    int n;
    n = (cur_line.size() > 64) ? 64 : cur_line.size();
    for (int i = 0; i < n; i++) exp_q.push_back({row, (i == n - 1), 2'b00, cur_line[i]});
    cur_line.delete();
  endtask

  task automatic wait_tvalid(input string tag);
    int k = 0;
    while (out_tvalid !== 1'b1 && k < 100) begin tick(1); k++; end
    chk(tag, 32'(out_tvalid), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || out_tvalid === 1'b1) && k < 3000) begin tick(1); k++; end
    tick(2);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int vcnt;
    logic [31:0] oe_exp;
    tick(4);
    chk("rst_tvalid", 32'(out_tvalid), 0);
    chk("rst_tlast", 32'(out_tlast), 0);
    chk("rst_tdata", 32'(out_tdata), 0);
    chk("rst_row", 32'(out_row), 0);
    chk("rst_errs", 32'({err_overflow, err_toolong}), 0);
    chk("rst_lines", 32'(line_count), 0);
    chk("rst_oe", oe_cycles, 0);
    aresetn = 1'b1;
    tick(3);

    // 64 pixels of 0x15 on row 5
    out_tready = 1'b1;
    for (int i = 0; i < 64; i++) shift_px(6'h15);
    expect_line(5'd5);
    pulse_lat(5'd5);
    drain("line64_drain");
    chk("line64_beats", beats, 64);
    chk("line64_count", 32'(line_count), 1);
    chk("line64_errs", 32'({err_overflow, err_toolong}), 0);

    // short line with back-pressure
    out_tready = 1'b0;
    shift_px(6'h3F); shift_px(6'h01); shift_px(6'h2A);
    expect_line(5'd9);
    pulse_lat(5'd9);
    wait_tvalid("stall_valid");
    for (int i = 0; i < 10; i++) begin
      chk("stall_tdata", 32'(out_tdata), 32'h3F);
      chk("stall_row", 32'(out_row), 9);
      tick(1);
    end
    out_tready = 1'b1;
    drain("stall_drain");
    chk("stall_beats", beats, 67);
    chk("stall_count", 32'(line_count), 2);

    // second line latched while the first is still streaming
    out_tready = 1'b0;
    for (int i = 0; i < 64; i++) shift_px(6'(i));
    expect_line(5'd3);
    pulse_lat(5'd3);
    wait_tvalid("ovf_valid");
    for (int i = 0; i < 5; i++) shift_px(6'(i + 40));
    cur_line.delete();
    pulse_lat(5'd4);
    tick(4);
    chk("ovf_flag", 32'(err_overflow), 1);
    out_tready = 1'b1;
    drain("ovf_drain");
    chk("ovf_beats", beats, 131);
    chk("ovf_count", 32'(line_count), 3);

    // overlong line truncated to WIDTH
    for (int i = 0; i < 70; i++) shift_px(6'(i + 7));
    expect_line(5'd7);
    pulse_lat(5'd7);
    chk("long_flag", 32'(err_toolong), 1);
    drain("long_drain");
    chk("long_beats", beats, 195);
    chk("long_count", 32'(line_count), 4);
    chk("long_ovf_sticky", 32'(err_overflow), 1);

    // latch with no pixels
    pulse_lat(5'd2);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_tvalid === 1'b1) vcnt++;
      tick(1);
    end
    chk("empty_valid", vcnt, 0);
    chk("empty_count", 32'(line_count), 4);

    // output-enable statistics, then reset mid-stream
    hub75io_oe = 1'b0;
    tick(100);
    hub75io_oe = 1'b1;
    tick(6);
`ifdef HUB75_RX_OE_STATS_EN
    oe_exp = 32'd100;
`else
    oe_exp = 32'd0;
`endif
    chk("oe_cycles", oe_cycles, oe_exp);

    out_tready = 1'b0;
    for (int i = 0; i < 64; i++) shift_px(6'(i * 3));
    cur_line.delete();
    pulse_lat(5'd1);
    wait_tvalid("mid_valid");
    aresetn = 1'b0;
    tick(1);
    chk("mid_tvalid", 32'(out_tvalid), 0);
    chk("mid_tdata", 32'(out_tdata), 0);
    chk("mid_row", 32'(out_row), 0);
    chk("mid_count", 32'(line_count), 0);
    chk("mid_oe", oe_cycles, 0);
    chk("mid_errs", 32'({err_overflow, err_toolong}), 0);
    tick(2);
    aresetn = 1'b1;
    out_tready = 1'b1;
    tick(150);
    chk("mid_no_beats", beats, 195);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning columns per line (range 2..256).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per HUB75 input (range 2..4).
REQ-003 SHALL have port clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port aresetn, input, 1, synchronous active-low reset sampled on rising clock.
REQ-005 SHALL have ports hub75io_clk, hub75io_lat and hub75io_oe, each input, 1, panel shift clock, latch strobe and active-low output enable.
REQ-006 SHALL have ports hub75io_r, hub75io_g and hub75io_b, each input, 2, upper-half (bit 0) and lower-half (bit 1) colour data.
REQ-007 SHALL have ports hub75io_row_a through hub75io_row_e, each input, 1, row address bits 0..4.
REQ-008 SHALL have ports out_tdata (output, 8), out_tvalid (output, 1), out_tready (input, 1) and out_tlast (output, 1), forming the AXI-Stream line output.
REQ-009 SHALL have port out_row, output, 5, row address of the line being streamed.
REQ-010 SHALL have ports err_overflow and err_toolong, each output, 1, sticky error flags.
REQ-011 SHALL have ports line_count (output, 16) and oe_cycles (output, 32), statistics counters.

Function
REQ-012 SHALL pass every HUB75 input through SYNC_STAGES flops plus one edge-detect flop, all inputs on an identical pipeline.
REQ-013 SHALL capture pixel {2'b00,b[1],g[1],r[1],b[0],g[0],r[0]} on each synchronized hub75io_clk rising edge into the fill buffer at column col, then increment col.
- Pixel write occurs SYNC_STAGES+1 clocks after the pin edge.
- hub75io_clk period SHALL be at least 4 clocks.
REQ-014 SHALL, when col equals WIDTH, discard further pixels until the next latch and set err_toolong.
REQ-015 SHALL use two line buffers in ping-pong: fill, then stream.
REQ-016 On a synchronized lat rising edge with col>0 and the other buffer idle, SHALL swap buffers, record length=col and out_row={e,d,c,b,a}, and reset col to 0.
REQ-017 On a lat edge with col==0, SHALL produce no output and leave counters unchanged.
REQ-018 On a lat edge while the other buffer is still streaming, SHALL drop the filled line, set err_overflow, and reset col to 0.
REQ-019 Stream FSM SHALL have states IDLE, READ and SEND:
- IDLE->READ on swap.
- READ->SEND after one clock (buffer read latency).
- SEND holds while !out_tready.
- SEND advances the index on each handshake.
- After the handshake with out_tlast asserted, SEND->IDLE.
REQ-020 out_tvalid SHALL rise exactly 2 clocks after the swap clock; out_tdata, out_tlast and out_row SHALL be stable while out_tvalid && !out_tready.
REQ-021 out_tlast SHALL assert only on index length-1.
REQ-022 SHALL increment line_count (wrapping at 2^16) on each tlast handshake.
REQ-023 A lat edge and a clk edge detected on the same clock SHALL write the pixel before the swap (pixel is included in the line).
REQ-024 Error flags SHALL clear only on reset.

Reset
REQ-025 When aresetn is low at a clock edge, SHALL clear at the next edge:
- all outputs: out_tvalid=0, out_tlast=0, out_tdata=0, out_row=0;
- err_overflow and err_toolong;
- line_count and oe_cycles;
- col, FSM state (IDLE) and synchronizers.
REQ-026 Reset mid-line or mid-stream SHALL discard partial data with no further beats.

Configuration
REQ-027 Macro HUB75_RX_OE_STATS_EN SHALL control the oe_cycles counter:
- Defined: oe_cycles counts clocks with synchronized hub75io_oe==0, saturating at 2^32-1.
- Undefined: oe_cycles is tied to 0 and no counter logic is built.

Verification
REQ-028 Shift 64 pixels of 0x15, then lat with row 5 -> 64 beats of 0x15, tlast on beat 64, out_row=5, line_count=1.
REQ-029 Shift 3 pixels, lat, hold out_tready=0 for 10 clocks -> tdata stable, no beat lost, 3 beats total.
REQ-030 Stream a 64-pixel line with tready=0, then shift a second line and lat -> err_overflow=1, only the first line emitted.
REQ-031 Shift 70 pixels, lat -> err_toolong=1, exactly 64 beats.
REQ-032 Lat with no shifts -> no out_tvalid, line_count unchanged.
REQ-033 Hold oe=0 for 100 clocks (macro defined) -> oe_cycles=100, then reset mid-stream -> out_tvalid=0 next clock, all counters 0.
